// File: rtl/pipe_hazard_controller_pkg.sv
// Shared types for the pipelined hazard controller: ALU ops, forwarding selects,
// memory FSM states, result-source codes and the packed stage-control records.
package pipe_hazard_controller_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] funct3;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic       alu_src_b;
    alu_op_t    alu_op;
  } de_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } em_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } mw_ctrl_t;

  // alu_class: 00 add (address calc), 01 sub (branch compare), 10 funct-decoded, 11 pass B (lui)
  function automatic alu_op_t alu_decode(input logic [1:0] alu_class,
                                         input logic [2:0] funct3,
                                         input logic       funct7b5,
                                         input logic       op_b5);
    alu_op_t op;
    op = ALU_ADD;
    case (alu_class)
      2'b00: op = ALU_ADD;
      2'b01: op = ALU_SUB;
      2'b11: op = ALU_PASS_B;
      default: begin
        case (funct3)
          3'b000:  op = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pipe_hazard_controller_ctrl_stage_reg.sv
// Pipeline control register with hold (en low) and bubble insertion (clr high).
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_hazard_controller.sv
// Five-stage RV32I control path: decode, hazard/forwarding, branch flush and memory handshake.
// Optional BRANCH_FULL_EN selects the branch condition from funct3 (else BEQ-only).
//
// state  | meaning
// M_IDLE | no access outstanding; an access acked this cycle completes with zero wait
// M_WAIT | access outstanding; waiting for mem_ack_m or wait-counter timeout
module pipe_hazard_controller
  import pipe_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_CNT_W = $clog2(MAX_WAIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_d,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  input  logic                  mem_ack_m,
  output logic [2:0]            imm_src_d,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  pc_src_e,
  output fwd_sel_t              forward_a_e,
  output fwd_sel_t              forward_b_e,
  output logic                  alu_src_a_e,
  output logic                  alu_src_b_e,
  output alu_op_t               alu_op_e,
  output logic [1:0]            result_src_e,
  output logic [1:0]            result_src_w,
  output logic                  mem_req_m,
  output logic                  mem_write_m,
  output logic                  reg_write_m,
  output logic                  reg_write_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic                  mem_err
);

  localparam int DE_W = $bits(de_ctrl_t) + 3 * REG_ADDR_W;
  localparam int EM_W = $bits(em_ctrl_t) + REG_ADDR_W;
  localparam int MW_W = $bits(mw_ctrl_t) + REG_ADDR_W;
  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

  logic [6:0]            opcode_d;
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;
  logic [1:0]            alu_class_d;
  de_ctrl_t              dec_d;

  de_ctrl_t              de_e;
  logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e;
  em_ctrl_t              em_d, em_m;
  logic [REG_ADDR_W-1:0] rd_m;
  mw_ctrl_t              mw_d, mw_w;

  logic [DE_W-1:0] de_q;
  logic [EM_W-1:0] em_q;
  logic [MW_W-1:0] mw_q;

  mem_state_t            mem_state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  access_m, mem_stall, lw_stall, cond, branch_taken;

  assign opcode_d = instr_d[6:0];
  assign rs1_d    = instr_d[15 +: REG_ADDR_W];
  assign rs2_d    = instr_d[20 +: REG_ADDR_W];
  assign rd_d     = instr_d[7 +: REG_ADDR_W];

  always_comb begin
    dec_d        = '0;
    alu_class_d  = 2'b00;
    imm_src_d    = IMM_I;
    dec_d.funct3 = instr_d[14:12];
    case (opcode_d)
      OP_LOAD: begin
        dec_d.reg_write  = 1'b1;
        dec_d.alu_src_b  = 1'b1;
        dec_d.result_src = RES_MEM;
      end
      OP_STORE: begin
        dec_d.mem_write = 1'b1;
        dec_d.alu_src_b = 1'b1;
        imm_src_d       = IMM_S;
      end
      OP_R: begin
        dec_d.reg_write = 1'b1;
        alu_class_d     = 2'b10;
      end
      OP_I: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src_b = 1'b1;
        alu_class_d     = 2'b10;
      end
      OP_BRANCH: begin
        dec_d.branch = 1'b1;
        imm_src_d    = IMM_B;
        alu_class_d  = 2'b01;
      end
      OP_JAL: begin
        dec_d.reg_write  = 1'b1;
        dec_d.jump       = 1'b1;
        dec_d.result_src = RES_PC4;
        imm_src_d        = IMM_J;
      end
      OP_JALR: begin
        dec_d.reg_write  = 1'b1;
        dec_d.jump       = 1'b1;
        dec_d.alu_src_b  = 1'b1;
        dec_d.result_src = RES_PC4;
      end
      OP_LUI: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src_b = 1'b1;
        imm_src_d       = IMM_U;
        alu_class_d     = 2'b11;
      end
      OP_AUIPC: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src_a = 1'b1;
        dec_d.alu_src_b = 1'b1;
        imm_src_d       = IMM_U;
      end
      default: ;
    endcase
    dec_d.alu_op = alu_decode(alu_class_d, instr_d[14:12], instr_d[30], instr_d[5]);
  end

  // During a memory stall everything upstream of W freezes and W receives bubbles
  ctrl_stage_reg #(.W(DE_W)) u_de_reg (
    .clk (clk),
    .rst (rst),
    .en  (!mem_stall),
    .clr (flush_e),
    .d   ({dec_d, rs1_d, rs2_d, rd_d}),
    .q   (de_q)
  );
  assign {de_e, rs1_e, rs2_e, rd_e} = de_q;

  assign em_d.reg_write  = de_e.reg_write;
  assign em_d.mem_write  = de_e.mem_write;
  assign em_d.result_src = de_e.result_src;

  ctrl_stage_reg #(.W(EM_W)) u_em_reg (
    .clk (clk),
    .rst (rst),
    .en  (!mem_stall),
    .clr (1'b0),
    .d   ({em_d, rd_e}),
    .q   (em_q)
  );
  assign {em_m, rd_m} = em_q;

  assign mw_d.reg_write  = em_m.reg_write;
  assign mw_d.result_src = em_m.result_src;

  ctrl_stage_reg #(.W(MW_W)) u_mw_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (mem_stall),
    .d   ({mw_d, rd_m}),
    .q   (mw_q)
  );
  assign {mw_w, rd_w} = mw_q;

  assign alu_src_a_e  = de_e.alu_src_a;
  assign alu_src_b_e  = de_e.alu_src_b;
  assign alu_op_e     = de_e.alu_op;
  assign result_src_e = de_e.result_src;
  assign reg_write_m  = em_m.reg_write;
  assign reg_write_w  = mw_w.reg_write;
  assign result_src_w = mw_w.result_src;

  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    if (em_m.reg_write && rd_m != '0 && rd_m == rs1_e)      forward_a_e = FWD_M;
    else if (mw_w.reg_write && rd_w != '0 && rd_w == rs1_e) forward_a_e = FWD_W;
    if (em_m.reg_write && rd_m != '0 && rd_m == rs2_e)      forward_b_e = FWD_M;
    else if (mw_w.reg_write && rd_w != '0 && rd_w == rs2_e) forward_b_e = FWD_W;
  end

`ifdef BRANCH_FULL_EN
  always_comb begin
    cond = 1'b0;
    case (de_e.funct3)
      3'b000:  cond = zero_e;
      3'b001:  cond = !zero_e;
      3'b100:  cond = lt_e;
      3'b101:  cond = !lt_e;
      3'b110:  cond = ltu_e;
      3'b111:  cond = !ltu_e;
      default: cond = 1'b0;
    endcase
  end
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_d[31], instr_d[29:25]};
`else
  assign cond = zero_e;
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_d[31], instr_d[29:25], lt_e, ltu_e, de_e.funct3};
`endif

  assign branch_taken = de_e.branch && cond;
  assign access_m     = em_m.mem_write || (em_m.result_src == RES_MEM);
  assign mem_req_m    = (mem_state == M_WAIT) || access_m;
  assign mem_write_m  = mem_req_m && em_m.mem_write;
  assign mem_stall    = ((mem_state == M_IDLE) && access_m && !mem_ack_m) ||
                        ((mem_state == M_WAIT) && !mem_ack_m && (wait_cnt != MAX_CNT));

  assign lw_stall = (de_e.result_src == RES_MEM) && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  assign pc_src_e = (branch_taken || de_e.jump) && !mem_stall;
  assign flush_d  = pc_src_e;
  assign flush_e  = !mem_stall && (pc_src_e || lw_stall);
  // A taken branch/jump discards the dependent instruction, so the load-use stall is moot
  assign stall_f  = mem_stall || (lw_stall && !pc_src_e);
  assign stall_d  = stall_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_state <= M_IDLE;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (mem_state)
        M_IDLE: begin
          if (access_m && !mem_ack_m) begin
            mem_state <= M_WAIT;
            wait_cnt  <= '0;
          end
        end
        M_WAIT: begin
          if (mem_ack_m) begin
            mem_state <= M_IDLE;
            wait_cnt  <= '0;
          end else if (wait_cnt == MAX_CNT) begin
            mem_state <= M_IDLE;
            wait_cnt  <= '0;
            mem_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: mem_state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Directed self-checking bench for pipe_hazard_controller (hazards, forwarding, branches, memory FSM).
module tb_pipe_hazard_controller;
  import pipe_hazard_controller_pkg::*;

  localparam int MAXW = 15;
`ifdef BRANCH_FULL_EN
  localparam logic FULL_EN = 1'b1;
`else
  localparam logic FULL_EN = 1'b0;
`endif

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] LW5    = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] LW0    = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] ADD652 = {7'b0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] ADD602 = {7'b0, 5'd2, 5'd0, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] ADD312 = {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] ADD332 = {7'b0, 5'd2, 5'd3, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] SUB433 = {7'b0100000, 5'd3, 5'd3, 3'b000, 5'd4, 7'b0110011};
  localparam logic [31:0] ADDI01 = {12'd5, 5'd1, 3'b000, 5'd0, 7'b0010011};
  localparam logic [31:0] ADD700 = {7'b0, 5'd0, 5'd0, 3'b000, 5'd7, 7'b0110011};
  localparam logic [31:0] BEQ    = {7'b0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
  localparam logic [31:0] BNE    = {7'b0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b1100011};
  localparam logic [31:0] BLTU   = {7'b0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011};
  localparam logic [31:0] JAL1   = {20'd0, 5'd1, 7'b1101111};
  localparam logic [31:0] SW     = {7'b0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        zero_e, lt_e, ltu_e, mem_ack_m;
  logic [2:0]  imm_src_d;
  logic        stall_f, stall_d, flush_d, flush_e, pc_src_e;
  fwd_sel_t    forward_a_e, forward_b_e;
  logic        alu_src_a_e, alu_src_b_e;
  alu_op_t     alu_op_e;
  logic [1:0]  result_src_e, result_src_w;
  logic        mem_req_m, mem_write_m, reg_write_m, reg_write_w;
  logic [4:0]  rd_w;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  pipe_hazard_controller #(.REG_ADDR_W(5), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
    .mem_ack_m(mem_ack_m), .imm_src_d(imm_src_d), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .pc_src_e(pc_src_e), .forward_a_e(forward_a_e),
    .forward_b_e(forward_b_e), .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e),
    .alu_op_e(alu_op_e), .result_src_e(result_src_e), .result_src_w(result_src_w),
    .mem_req_m(mem_req_m), .mem_write_m(mem_write_m), .reg_write_m(reg_write_m),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Advance one clock, present a new D-stage instruction, let combinational outputs settle
  task automatic cyc(input logic [31:0] ins);
    @(posedge clk);
    #1;
    instr_d = ins;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cyc(NOP);
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_d = 32'd0; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0; mem_ack_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({stall_f, stall_d, flush_d, flush_e, pc_src_e, forward_a_e, forward_b_e, alu_src_a_e,
         alu_src_b_e, alu_op_e, result_src_e, result_src_w, mem_req_m, mem_write_m, reg_write_m,
         reg_write_w, rd_w, mem_err, imm_src_d} !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, expected all zero");
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req_m !== 1'b0 || stall_f !== 1'b0) begin
      errors++; $display("FAIL reset_release: req=%b stall_f=%b expected 0 0", mem_req_m, stall_f);
    end
  endtask

  task automatic test_load_use();
    drain();
    cyc(LW5);
    cyc(ADD652);
    checks++;
    if ({stall_f, stall_d, flush_e, flush_d} !== 4'b1110) begin
      errors++; $display("FAIL lu_stall: got sf,sd,fe,fd=%b expected 1110", {stall_f, stall_d, flush_e, flush_d});
    end
    cyc(ADD652);
    checks++;
    if (stall_f !== 1'b0 || mem_req_m !== 1'b1) begin
      errors++; $display("FAIL lu_bubble: stall_f=%b req=%b expected 0 1", stall_f, mem_req_m);
    end
    cyc(NOP);
    checks++;
    if (forward_a_e !== FWD_W || forward_b_e !== FWD_RF) begin
      errors++; $display("FAIL lu_fwd: a=%b b=%b expected 01 00", forward_a_e, forward_b_e);
    end
    checks++;
    if (rd_w !== 5'd5 || result_src_w !== RES_MEM) begin
      errors++; $display("FAIL lu_wb: rd_w=%0d res=%b expected 5 01", rd_w, result_src_w);
    end
    drain();
    cyc(LW0);
    cyc(ADD602);
    checks++;
    if (stall_f !== 1'b0 || flush_e !== 1'b0) begin
      errors++; $display("FAIL lu_x0: stall_f=%b flush_e=%b expected 0 0", stall_f, flush_e);
    end
  endtask

  task automatic test_forwarding();
    drain();
    cyc(ADD312);
    cyc(SUB433);
    checks++;
    if (stall_f !== 1'b0) begin
      errors++; $display("FAIL fwd_m_nostall: stall_f=%b expected 0", stall_f);
    end
    cyc(NOP);
    checks++;
    if (forward_a_e !== FWD_M || forward_b_e !== FWD_M) begin
      errors++; $display("FAIL fwd_m: a=%b b=%b expected 10 10", forward_a_e, forward_b_e);
    end
    checks++;
    if (alu_op_e !== ALU_SUB || reg_write_m !== 1'b1) begin
      errors++; $display("FAIL fwd_m_ctrl: op=%0d rwm=%b expected %0d 1", alu_op_e, reg_write_m, ALU_SUB);
    end
    drain();
    cyc(ADD312); cyc(NOP); cyc(SUB433); cyc(NOP);
    checks++;
    if (forward_a_e !== FWD_W || forward_b_e !== FWD_W) begin
      errors++; $display("FAIL fwd_w: a=%b b=%b expected 01 01", forward_a_e, forward_b_e);
    end
    drain();
    cyc(ADD312); cyc(ADD332); cyc(SUB433); cyc(NOP);
    checks++;
    if (forward_a_e !== FWD_M || forward_b_e !== FWD_M) begin
      errors++; $display("FAIL fwd_prio: a=%b b=%b expected 10 10", forward_a_e, forward_b_e);
    end
    drain();
    cyc(ADDI01); cyc(ADD700); cyc(NOP);
    checks++;
    if (forward_a_e !== FWD_RF || forward_b_e !== FWD_RF) begin
      errors++; $display("FAIL fwd_x0: a=%b b=%b expected 00 00", forward_a_e, forward_b_e);
    end
  endtask

  task automatic test_branch();
    drain();
    zero_e = 1'b0;
    cyc(BEQ); cyc(NOP);
    zero_e = 1'b1; #1;
    checks++;
    if ({pc_src_e, flush_d, flush_e, stall_f} !== 4'b1110) begin
      errors++; $display("FAIL beq_taken: pc,fd,fe,sf=%b expected 1110", {pc_src_e, flush_d, flush_e, stall_f});
    end
    cyc(NOP);
    checks++;
    if ({pc_src_e, flush_d, flush_e} !== 3'b000) begin
      errors++; $display("FAIL beq_one_cycle: pc,fd,fe=%b expected 000", {pc_src_e, flush_d, flush_e});
    end
    zero_e = 1'b0;
    cyc(BEQ); cyc(NOP);
    checks++;
    if ({pc_src_e, flush_d, flush_e} !== 3'b000) begin
      errors++; $display("FAIL beq_not_taken: pc,fd,fe=%b expected 000", {pc_src_e, flush_d, flush_e});
    end
    cyc(JAL1); cyc(NOP);
    checks++;
    if (pc_src_e !== 1'b1 || result_src_e !== RES_PC4) begin
      errors++; $display("FAIL jal: pc=%b res=%b expected 1 10", pc_src_e, result_src_e);
    end
  endtask

  task automatic test_branch_full();
    drain();
    zero_e = 1'b0; ltu_e = 1'b0;
    cyc(BNE); cyc(NOP);
    checks++;
    if (pc_src_e !== FULL_EN) begin
      errors++; $display("FAIL bne_nz: pc=%b expected %b", pc_src_e, FULL_EN);
    end
    cyc(BLTU); cyc(NOP);
    checks++;
    if (pc_src_e !== 1'b0) begin
      errors++; $display("FAIL bltu_f: pc=%b expected 0", pc_src_e);
    end
    cyc(BLTU); cyc(NOP);
    ltu_e = 1'b1; #1;
    checks++;
    if (pc_src_e !== FULL_EN) begin
      errors++; $display("FAIL bltu_t: pc=%b expected %b", pc_src_e, FULL_EN);
    end
    ltu_e = 1'b0;
  endtask

  task automatic test_store_wait();
    int req_n, stall_n, wr_n;
    drain();
    mem_ack_m = 1'b1;
    cyc(ADD312); cyc(SW); cyc(NOP);
    req_n = 0; stall_n = 0; wr_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      mem_ack_m = (i == 3);
      instr_d = NOP;
      #1;
      if (mem_req_m) req_n++;
      if (stall_f) stall_n++;
      if (mem_write_m) wr_n++;
      if (i == 0) begin
        checks++;
        if (reg_write_w !== 1'b1 || rd_w !== 5'd3) begin
          errors++; $display("FAIL sw_prev_w: rww=%b rd_w=%0d expected 1 3", reg_write_w, rd_w);
        end
      end
      if (i == 1) begin
        checks++;
        if (reg_write_w !== 1'b0 || rd_w !== 5'd0) begin
          errors++; $display("FAIL sw_bubble: rww=%b rd_w=%0d expected 0 0", reg_write_w, rd_w);
        end
      end
    end
    checks++;
    if (req_n != 4 || stall_n != 3 || wr_n != 4) begin
      errors++; $display("FAIL sw_wait: req=%0d stall=%0d wr=%0d expected 4 3 4", req_n, stall_n, wr_n);
    end
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL sw_no_err: mem_err=%b expected 0", mem_err);
    end
    mem_ack_m = 1'b1;
  endtask

  task automatic test_timeout();
    int req_n, stall_n;
    drain();
    cyc(LW5); cyc(NOP);
    mem_ack_m = 1'b0;
    req_n = 0; stall_n = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(NOP);
      if (mem_req_m) req_n++;
      if (stall_f) stall_n++;
      if (i == MAXW + 1) begin
        checks++;
        if (mem_err !== 1'b0 || stall_f !== 1'b0 || mem_req_m !== 1'b1) begin
          errors++; $display("FAIL to_last: err=%b sf=%b req=%b expected 0 0 1", mem_err, stall_f, mem_req_m);
        end
      end
    end
    checks++;
    if (req_n != MAXW + 2 || stall_n != MAXW + 1) begin
      errors++; $display("FAIL to_count: req=%0d stall=%0d expected %0d %0d", req_n, stall_n, MAXW + 2, MAXW + 1);
    end
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL to_err: mem_err=%b expected 1", mem_err);
    end
    mem_ack_m = 1'b1;
    cyc(ADD312); cyc(NOP); cyc(NOP);
    checks++;
    if (mem_err !== 1'b1 || stall_f !== 1'b0 || reg_write_m !== 1'b1) begin
      errors++; $display("FAIL to_resume: err=%b sf=%b rwm=%b expected 1 0 1", mem_err, stall_f, reg_write_m);
    end
    rst = 1'b1;
    cyc(NOP);
    rst = 1'b0;
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL to_rst_clear: mem_err=%b expected 0", mem_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    drain();
    mem_ack_m = 1'b0;
    cyc(SW); cyc(NOP); cyc(NOP); cyc(NOP);
    checks++;
    if (mem_req_m !== 1'b1 || stall_f !== 1'b1) begin
      errors++; $display("FAIL mid_wait_req: req=%b sf=%b expected 1 1", mem_req_m, stall_f);
    end
    rst = 1'b1;
    cyc(NOP);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req_m !== 1'b0 || stall_f !== 1'b0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL mid_wait_rst: req=%b sf=%b err=%b expected 0 0 0", mem_req_m, stall_f, mem_err);
    end
    mem_ack_m = 1'b1;
    cyc(NOP);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_branch_full();
    test_store_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
